// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with instruction
// memory and hands one instruction (or a NOP bubble) per advance to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_stall,
    input  logic        stall,
    input  logic        data_hazard,
    input  logic        control_hazard,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_word;

    logic        acked;
    logic        have_word;
    logic        deliver;
    logic [31:0] word;
    logic [31:0] target;
    logic [31:0] pc_next;

    // The request never looks at stall, otherwise imem_stall would loop back into itself.
    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    imem_req = ~control_hazard;
                WAIT:    imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign imem_stall = imem_req & ~imem_ack;

    assign acked     = imem_req & imem_ack;
    assign have_word = acked | (state == HOLD);
    assign word      = (state == HOLD) ? buf_word : imem_rdata;
    assign target    = {jump_target[31:2], 2'b00};
    assign pc_next   = pc + 32'd4;
    assign deliver   = ~stall & have_word & ~jump_taken & ~data_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= IDLE;
            buf_word   <= 32'h0;
            inst       <= NOP_INST;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
        end else begin
            if (imem_req && !imem_ack) begin
                state <= WAIT;
            end else if (stall) begin
                // Frozen pipeline: a word that arrives now is parked until it can move on.
                if (acked) begin
                    buf_word <= imem_rdata;
                    state    <= HOLD;
                end
            end else if (have_word) begin
                if (jump_taken) begin
                    pc    <= target;
                    state <= IDLE;
                end else if (data_hazard) begin
                    buf_word <= word;
                    state    <= HOLD;
                end else begin
                    inst       <= word;
                    inst_pc    <= pc;
                    inst_valid <= 1'b1;
                    pc         <= pc_next;
                    state      <= IDLE;
                end
            end else if (jump_taken) begin
                pc <= target;
            end

            if (!stall && control_hazard && !deliver) begin
                inst       <= NOP_INST;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the hazards controller and the decode stage. It owns the PC and runs a request/acknowledge handshake with instruction memory. It reports `imem_stall` to the hazards controller and consumes that controller's `stall`, `data_hazard` and `control_hazard`. It delivers one instruction, its PC and a valid flag per advance to decode, inserting NOP bubbles on control hazards and holding on data hazards.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request; once raised, held with `imem_addr` stable until `imem_ack`.
- `imem_addr`  out  32: fetch address (= `pc`).
- `imem_rdata`  in  32: instruction word; valid only in the `imem_ack` cycle.
- `imem_ack`  in  1: completes the request in the same cycle; ignored when `imem_req`=0.
- `imem_stall`  out  1: `imem_req & ~imem_ack`, combinational, to the hazards controller.
- `stall`  in  1: global freeze (`dmem_stall | imem_stall`).
- `data_hazard`  in  1: decode must hold its instruction.
- `control_hazard`  in  1: squash (jump cycle plus one following cycle).
- `jump_taken`  in  1: redirect request from execute.
- `jump_target`  in  32: redirect address; bits [1:0] forced to 0.
- `inst`  out  32: instruction to decode.
- `inst_pc`  out  32: PC of `inst`.
- `inst_valid`  out  1: `inst` is a real fetched instruction, not a bubble.

## Operation
- State register values: IDLE (no request outstanding), WAIT (request outstanding), HOLD (fetched word parked in `buf`).
- `imem_req`:
  - 0 during `rst`.
  - In IDLE: `~control_hazard`.
  - In WAIT: 1.
  - In HOLD: 0.
  - Never a function of `stall` (avoids a combinational loop through `imem_stall`).
- IDLE, `req & ~ack` → WAIT.
- Ack cycle (IDLE or WAIT with `imem_ack`=1). Priority order:
  - `stall`: `buf<=imem_rdata`, → HOLD.
  - `jump_taken`: discard rdata, `pc<=jump_target`, output bubble, → IDLE.
  - `data_hazard`: `buf<=imem_rdata`, → HOLD.
  - Otherwise: `inst<=rdata`, `inst_pc<=pc`, `inst_valid<=1`, `pc<=pc+4`, → IDLE.
- IDLE with no request, `~stall & jump_taken`: `pc<=jump_target`, output bubble.
- HOLD, when `~stall`:
  - `jump_taken`: drop `buf`, redirect, bubble, → IDLE.
  - `data_hazard`: stay.
  - Otherwise: load `buf` to outputs as in the ack case, `pc+=4`, → IDLE.
- Output register:
  - Frozen whenever `stall`=1.
  - On `~stall & control_hazard` it loads `NOP_INST` with `inst_valid`=0; `inst_pc` is unchanged.
  - On `data_hazard` (with no bubble) it holds.
- An outstanding request is never cancelled. A jump arriving while in WAIT is resolved at the ack, because `imem_stall` freezes execute, which keeps `jump_taken` asserted.
- `pc+4` wraps modulo 2^32 (0xFFFF_FFFC → 0).

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - state = IDLE
  - `inst` = `NOP_INST`
  - `inst_pc` = 0
  - `inst_valid` = 0
  - `buf` = 0
  - `imem_req` = 0 and `imem_stall` = 0 while `rst` is high.
- First request is the cycle after `rst` falls, with `imem_addr` = `RESET_PC`.
- Zero-wait memory (ack in the request cycle): one instruction per cycle; `inst` is valid the cycle after the ack.
- N-wait memory: `imem_stall` is high for N cycles, then `inst` updates on the edge after the ack.
- Redirect: the `jump_taken` edge loads `pc`. The next cycle is squashed (`req`=0 because `control_hazard` is latched). The target request is issued 2 cycles after `jump_taken`.
- `rst` mid-request: state returns to IDLE and any late ack is ignored (`req`=0).
- Simultaneous `stall` and `jump_taken`: stall wins; the redirect happens on the first unstalled edge.

## Test plan
- Reset, zero-wait memory returning 0x0000_0093 at 0, 0x0010_0113 at 4 → `imem_addr` 0, 4, 8 on consecutive cycles; `inst`/`inst_pc` = 0x93/0 then 0x00100113/4; `inst_valid`=1.
- Ack delayed 3 cycles at addr 8 → `imem_stall`=1 for exactly 3 cycles; `imem_addr` stable at 8; `inst` unchanged until the edge after the ack.
- `jump_taken`=1 with `jump_target`=0x103 at the ack of addr 0x20 → word dropped; `pc`=0x100; next cycle `imem_req`=0 and `inst`=0x13 with `inst_valid`=0; request to 0x100 issued 2 cycles after the jump.
- `dmem_stall` (`stall`=1) for 2 cycles during the ack of addr 0x40 → HOLD with `req`=0; the word appears on `inst` with `inst_pc`=0x40 on the first edge after the stall drops.
- `data_hazard`=1 for 2 cycles → `inst` held; the next word is parked in `buf`, no new request is issued, and it is released once the hazard clears.
- `pc`=0xFFFF_FFFC with an ack → next `imem_addr`=0x0000_0000.
